// File: rtl/de_frame_store.sv
// Drawing-engine bus responder for a 32-bit word-write frame-store RAM.
// Partial writes are handled as read-modify-write; every transaction ends with a one-cycle de_ack.
module de_frame_store #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [17:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDWAIT,
    S_WR,
    S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] nbyte_q, nbyte_d;
  logic          rnw_q, rnw_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] merged;
  logic [DW-1:0] wr_word;

  // Masked-off bytes keep the RAM contents, enabled bytes take the new data.
  always_comb begin
    merged = '0;
    for (int i = 0; i < int'(BW); i++) begin
      merged[8*i +: 8] = nbyte_q[i] ? mem_rdata[8*i +: 8] : wdata_q[8*i +: 8];
    end
  end

  // Next-state and registered-output logic; outputs follow the state being entered.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    nbyte_d     = nbyte_q;
    rnw_d       = rnw_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    r_data_d    = r_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_word     = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (de_req) begin
          addr_d  = de_addr;
          nbyte_d = de_nbyte;
          rnw_d   = de_rnw;
          wdata_d = de_w_data;
          wr_word = de_w_data;
          if (de_rnw)                    state_d = S_RD;
          else if (de_nbyte == '0)       state_d = S_WR;
          else if (de_nbyte == {BW{1'b1}}) state_d = S_ACK;
          else                           state_d = S_RD;
        end
      end
      S_RD: begin
        cnt_d   = CW'(WAIT_STATES);
        state_d = S_RDWAIT;
      end
      S_RDWAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rnw_q) begin
          r_data_d = mem_rdata;
          state_d  = S_ACK;
        end else begin
          wr_word = merged;
          state_d = S_WR;
        end
      end
      S_WR:    state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_en_d = (state_d == S_RD) || (state_d == S_WR);
    mem_we_d = (state_d == S_WR);
    if (mem_en_d) mem_addr_d  = addr_d;
    if (mem_we_d) mem_wdata_d = wr_word;
    ack_d  = (state_d == S_ACK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      nbyte_q     <= '0;
      rnw_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      r_data_q    <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      nbyte_q     <= nbyte_d;
      rnw_q       <= rnw_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      r_data_q    <= r_data_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign de_ack    = ack_q;
  assign de_r_data = r_data_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_de_frame_store.sv
// Self-checking bench for de_frame_store: vector table with scoreboard queue,
// plus back-to-back stream and mid-transaction reset sequences.
module tb_de_frame_store;

  localparam int W = 2;
  localparam int NSTREAM = 640;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_req = 1'b0;
  logic        de_ack;
  logic [17:0] de_addr = '0;
  logic [3:0]  de_nbyte = '0;
  logic        de_rnw = 1'b0;
  logic [31:0] de_w_data = '0;
  logic [31:0] de_r_data;
  logic        busy;
  logic        mem_en;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  de_frame_store #(.WAIT_STATES(W)) dut (
    .clk(clk), .rst_n(rst_n), .de_req(de_req), .de_ack(de_ack),
    .de_addr(de_addr), .de_nbyte(de_nbyte), .de_rnw(de_rnw),
    .de_w_data(de_w_data), .de_r_data(de_r_data), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model with a backdoor preload port and strobe counters.
  logic [31:0] ram [0:262143];
  logic        bd_we = 1'b0;
  logic [17:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [17:0] addr;
    logic [3:0]  nbyte;
    logic        rnw;
    logic [31:0] wdata;
    logic [31:0] preset;
    int          ack;
    int          nrd;
    int          nwr;
    logic [31:0] exp_w;
    logic [31:0] exp_ram;
  } vec_t;

  vec_t        vecs [8];
  vec_t        sb_q [$];
  vec_t        e;
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [17:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // One transaction; cycle c is observed 1 time unit after the c-th edge past cycle 0.
  task automatic run_txn(input logic [17:0] a, input logic [3:0] nb, input logic rnw,
                         input logic [31:0] wd, output int ack_c, output int nrd,
                         output int nwr, output int rcyc, output int wcyc,
                         output logic [17:0] raddr, output logic [17:0] waddr,
                         output logic [31:0] wdat, output logic [31:0] rdat,
                         output logic busy_ok);
    de_addr = a; de_nbyte = nb; de_rnw = rnw; de_w_data = wd; de_req = 1'b1;
    ack_c = -1; nrd = 0; nwr = 0; rcyc = -1; wcyc = -1;
    raddr = '0; waddr = '0; wdat = '0; rdat = '0; busy_ok = 1'b1;
    for (int c = 1; c <= 40 && ack_c < 0; c++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b0;
      if (mem_en && mem_we)  begin nwr++; wcyc = c; waddr = mem_addr; wdat = mem_wdata; end
      if (mem_en && !mem_we) begin nrd++; rcyc = c; raddr = mem_addr; end
      if (de_ack) begin ack_c = c; rdat = de_r_data; end
    end
    de_req = 1'b0;
    de_addr = '1; de_w_data = '1; de_nbyte = 4'b0000;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] sdata(input int i);
    return 32'h9E3779B9 * 32'(i + 1);
  endfunction

  int ack_c, nrd, nwr, rcyc, wcyc;
  logic [17:0] raddr, waddr;
  logic [31:0] wdat, rdat;
  logic busy_ok;
  int acks, last_ack, cyc, wr0, rd0, bad;

  initial begin
    vecs[0] = '{18'h00010, 4'b0000, 1'b0, 32'hDEADBEEF, 32'h0,        2,     0, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{18'h00020, 4'b1110, 1'b0, 32'hAABBCCDD, 32'h11223344, 4 + W, 1, 1, 32'h112233DD, 32'h112233DD};
    vecs[2] = '{18'h3FFFF, 4'b0000, 1'b1, 32'h0,        32'hCAFEF00D, 3 + W, 1, 0, 32'h0,        32'hCAFEF00D};
    vecs[3] = '{18'h00011, 4'b0000, 1'b0, 32'h01234567, 32'h0,        2,     0, 1, 32'h01234567, 32'h01234567};
    vecs[4] = '{18'h00030, 4'b1111, 1'b0, 32'hFFFFFFFF, 32'h55555555, 1,     0, 0, 32'h0,        32'h55555555};
    vecs[5] = '{18'h00040, 4'b0101, 1'b0, 32'hAABBCCDD, 32'h11223344, 4 + W, 1, 1, 32'hAA22CC44, 32'hAA22CC44};
    vecs[6] = '{18'h00041, 4'b1011, 1'b0, 32'hAABBCCDD, 32'h11223344, 4 + W, 1, 1, 32'h11BB3344, 32'h11BB3344};
    vecs[7] = '{18'h00000, 4'b0110, 1'b1, 32'h0,        32'h0F0F0F0F, 3 + W, 1, 0, 32'h0,        32'h0F0F0F0F};

    repeat (2) @(posedge clk);
    #1;
    check("rst de_ack",    32'(de_ack), 32'h0);
    check("rst busy",      32'(busy), 32'h0);
    check("rst mem_en",    32'(mem_en), 32'h0);
    check("rst mem_we",    32'(mem_we), 32'h0);
    check("rst mem_addr",  32'(mem_addr), 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    check("rst de_r_data", de_r_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      preload(vecs[v].addr, vecs[v].preset);
      sb_q.push_back(vecs[v]);
      run_txn(vecs[v].addr, vecs[v].nbyte, vecs[v].rnw, vecs[v].wdata,
              ack_c, nrd, nwr, rcyc, wcyc, raddr, waddr, wdat, rdat, busy_ok);
      e = sb_q.pop_front();
      if (e.rnw) last_rd = e.preset;
      check($sformatf("v%0d ack cycle", v), 32'(ack_c), 32'(e.ack));
      check($sformatf("v%0d read strobes", v), 32'(nrd), 32'(e.nrd));
      check($sformatf("v%0d write strobes", v), 32'(nwr), 32'(e.nwr));
      if (e.nrd > 0) begin
        check($sformatf("v%0d read cycle", v), 32'(rcyc), 32'h1);
        check($sformatf("v%0d read addr", v), 32'(raddr), 32'(e.addr));
      end
      if (e.nwr > 0) begin
        check($sformatf("v%0d write cycle", v), 32'(wcyc), 32'(e.ack - 1));
        check($sformatf("v%0d write addr", v), 32'(waddr), 32'(e.addr));
        check($sformatf("v%0d write data", v), wdat, e.exp_w);
      end
      check($sformatf("v%0d de_r_data", v), rdat, last_rd);
      check($sformatf("v%0d ram word", v), ram[e.addr], e.exp_ram);
      check($sformatf("v%0d busy held", v), 32'(busy_ok), 32'h1);
      check($sformatf("v%0d idle after", v), 32'({busy, de_ack, mem_en}), 32'h0);
    end

    // Back-to-back full writes with de_req held high.
    wr0 = wr_cnt; rd0 = rd_cnt; acks = 0; last_ack = 0; cyc = 0;
    de_nbyte = 4'b0000; de_rnw = 1'b0; de_addr = 18'h100; de_w_data = sdata(0);
    de_req = 1'b1;
    while (acks < NSTREAM && cyc < NSTREAM * 3 + 50) begin
      @(posedge clk); #1;
      cyc++;
      if (de_ack) begin
        if (acks > 0) check("stream ack spacing", 32'(cyc - last_ack), 32'h3);
        last_ack = cyc;
        acks++;
        if (acks < NSTREAM) begin
          de_addr = 18'(32'h100 + 32'(acks));
          de_w_data = sdata(acks);
        end else de_req = 1'b0;
      end
    end
    de_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream acks", 32'(acks), 32'(NSTREAM));
    check("stream writes", 32'(wr_cnt - wr0), 32'(NSTREAM));
    check("stream reads", 32'(rd_cnt - rd0), 32'h0);
    bad = 0;
    for (int i = 0; i < NSTREAM; i++)
      if (ram[18'(32'h100 + 32'(i))] !== sdata(i)) bad++;
    check("stream ram words wrong", 32'(bad), 32'h0);

    // Reset while a partial write sits in RDWAIT.
    preload(18'h00050, 32'h76543210);
    wr0 = wr_cnt;
    de_addr = 18'h00050; de_nbyte = 4'b1100; de_rnw = 1'b0; de_w_data = 32'h89ABCDEF;
    de_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'h1);
    rst_n = 1'b0; de_req = 1'b0;
    @(posedge clk); #1;
    check("midrst de_ack",    32'(de_ack), 32'h0);
    check("midrst busy",      32'(busy), 32'h0);
    check("midrst mem_en",    32'(mem_en), 32'h0);
    check("midrst mem_we",    32'(mem_we), 32'h0);
    check("midrst mem_addr",  32'(mem_addr), 32'h0);
    check("midrst mem_wdata", mem_wdata, 32'h0);
    check("midrst de_r_data", de_r_data, 32'h0);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (mem_en || de_ack || busy) bad++;
    end
    check("post-reset activity", 32'(bad), 32'h0);
    check("post-reset writes", 32'(wr_cnt - wr0), 32'h0);
    check("post-reset ram word", ram[18'h00050], 32'h76543210);
    run_txn(18'h00050, 4'b0000, 1'b1, 32'h0,
            ack_c, nrd, nwr, rcyc, wcyc, raddr, waddr, wdat, rdat, busy_ok);
    check("recovery ack cycle", 32'(ack_c), 32'(3 + W));
    check("recovery read data", rdat, 32'h76543210);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
